io_bus_arbiter: RTL
===================

// Module: io_bus_arbiter
// PURPOSE
//  Shares the 16-bit I/O bus (ibus) between two masters: M0 = CPU-side dma
//  block, M1 = host monitor (UART debug path). Round-robin with bounded tenure.
//  Drives one slave port and routes fixed-latency read data back to its issuer.
//  Sits between cpu_top's ibus_* pins and the peripheral bus.
// PARAMETERS
//  AWIDTH    18  address width, bus address is [AWIDTH+1:2] (default = [19:2])
//  BWIDTH    16  bus data width
//  RD_LAT    1   slave read latency in cycles, s_rdata valid RD_LAT after s_ren (>=1)
//  HOLD_MAX  4   max accepted transfers per tenure when the other master waits (>=1)
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        asynchronous active-low reset
//  rst_pipe   in   1        sync flush: abort tenure, drop in-flight reads
//  mN_req     in   1        N=0,1: request, command held stable until accepted
//  mN_we      in   1        1=write, 0=read
//  mN_adr     in   AWIDTH   word address [AWIDTH+1:2]
//  mN_wdata   in   BWIDTH   write data
//  mN_gnt     out  1        registered grant, accept = mN_req & mN_gnt
//  mN_rvalid  out  1        read data valid for master N
//  mN_rdata   out  BWIDTH   read data (= s_rdata, both masters)
//  s_ren      out  1        slave read strobe
//  s_wen      out  1        slave write strobe
//  s_adr      out  AWIDTH   slave address
//  s_wdata    out  BWIDTH   slave write data
//  s_rdata    in   BWIDTH   slave read data
// BEHAVIOUR
//  Reset: state IDLE, mN_gnt=0, mN_rvalid=0, tenure cnt=0, last=M1 (M0 wins first tie).
//  FSM (registered): IDLE, GNT0, GNT1. gnt0=(state==GNT0), gnt1=(state==GNT1).
//  IDLE: no req -> IDLE; one req -> its GNTx; both -> master != last; last<=winner.
//  GNTx: accept=mx_req; cnt increments per accept.
//   mx_req=0 -> IDLE (one dead cycle, no strobe).
//   cnt reaches HOLD_MAX with other req=1 -> IDLE (other then wins, last=x).
//   cnt reaches HOLD_MAX with other req=0 -> stay, cnt<=0.
//   cnt cleared on every entry to GNTx; width $clog2(HOLD_MAX+1).
//  Slave drive (comb from granted master): s_ren=accept&~we, s_wen=accept&we,
//   s_adr/s_wdata=granted master's; in IDLE strobes 0, s_adr/s_wdata=0.
//  Back-to-back: accepts in consecutive cycles within a tenure (1 xfer/cycle).
//  Switch cost: >=1 IDLE cycle between tenures; never two grants at once.
//  Read return: RD_LAT-deep shift of {valid,id}; mN_rvalid=1 exactly RD_LAT
//   cycles after the accepting cycle; reads return in issue order, across tenure
//   switches too (pipe keeps running in IDLE).
//  Writes: no response; complete in accepting cycle.
//  rst_pipe=1: next cycle state=IDLE, gnt=0, cnt=0, return pipe cleared (pending
//   rvalid never asserts); strobes forced 0 in the rst_pipe cycle; last kept.
//  rst_n low mid-burst: all outputs to reset values immediately (async).
//  mN_req dropped while gnt=0: legal, no effect (withdrawn request).
// STRUCTURE
//  Shared package: FSM state encodings (ARB_IDLE/ARB_GNT0/ARB_GNT1), master id
//   constants (M_DMA=0, M_HOST=1).
//  One sub-module: io_rd_return_pipe (RD_LAT shift of {valid,id}, sync clear).
// TESTING
//  M0 write adr=0x00010 wdata=0xA5A5 from reset -> gnt0 cycle1, s_wen=1 adr=0x00010
//   wdata=0xA5A5 cycle1, req dropped cycle2 -> IDLE cycle2, gnt0=0 cycle3.
//  M1 read adr=0x3FFFF, s_rdata=0x1234, RD_LAT=1 -> s_ren at accept T, m1_rvalid=1
//   rdata=0x1234 at T+1, m0_rvalid=0 throughout.
//  Both req at cycle0 after reset, M0 burst of 6, HOLD_MAX=4 -> 4 M0 accepts, 1 IDLE,
//   M1 granted, then M0 resumes with remaining 2.
//  M0 alone, 10 reads, RD_LAT=3 -> 10 consecutive accepts, no IDLE, 10 m0_rvalid
//   pulses each 3 cycles after its accept.
//  rst_pipe in cycle after M1 read accept (RD_LAT=2) -> m1_rvalid never asserts,
//   gnt1=0 next cycle, M1 re-granted via IDLE if req held.
//  rst_n low mid-burst -> gnt/rvalid/strobes 0 immediately; after release tie -> M0.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_arbiter_pkg
//  Description : Shared encodings for the two-master I/O bus arbiter:
//                arbiter FSM states and master identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_bus_arbiter_pkg;

    // Arbiter FSM: idle, or bus granted to master 0 / master 1
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    // Master identifiers, also the id carried through the read-return pipe
    localparam logic M_DMA  = 1'b0;
    localparam logic M_HOST = 1'b1;

endpackage : io_bus_arbiter_pkg
`default_nettype wire

// File: rtl/io_rd_return_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : io_rd_return_pipe
//  Description : RD_LAT-deep shift register of {valid, id} that tags each
//                accepted read with its issuer so the slave's fixed-latency
//                read data can be routed back. Synchronous clear drops every
//                read still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_rd_return_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] valid_d;
    logic [RD_LAT-1:0] id_q;
    logic [RD_LAT-1:0] id_d;
    logic [RD_LAT-1:0] valid_shift;
    logic [RD_LAT-1:0] id_shift;

    // Stage 0 takes the new entry; deeper stages take the previous stage
    generate
        if (RD_LAT == 1) begin : g_single
            assign valid_shift = in_valid;
            assign id_shift    = in_id;
        end else begin : g_multi
            assign valid_shift = {valid_q[RD_LAT-2:0], in_valid};
            assign id_shift    = {id_q[RD_LAT-2:0], in_id};
        end
    endgenerate

    // Next pipe contents: shift, or empty when a flush is requested
    always_comb begin
        valid_d = valid_shift;
        id_d    = id_shift;
        if (clr) begin
            valid_d = '0;
            id_d    = '0;
        end
    end

    // Pipe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_id    = id_q[RD_LAT-1];

endmodule : io_rd_return_pipe
`default_nettype wire

// File: rtl/io_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_arbiter
//  Description : Round-robin arbiter with bounded tenure sharing one slave
//                port between the DMA master (M0) and the host monitor (M1).
//                Grants are registered; the slave strobes follow the granted
//                master combinationally; read data returns RD_LAT cycles
//                after acceptance, tagged to its issuer.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int AWIDTH   = 18,
    parameter int BWIDTH   = 16,
    parameter int RD_LAT   = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst_pipe,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AWIDTH-1:0] m0_adr,
    input  logic [BWIDTH-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [BWIDTH-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AWIDTH-1:0] m1_adr,
    input  logic [BWIDTH-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [BWIDTH-1:0] m1_rdata,
    output logic              s_ren,
    output logic              s_wen,
    output logic [AWIDTH-1:0] s_adr,
    output logic [BWIDTH-1:0] s_wdata,
    input  logic [BWIDTH-1:0] s_rdata
);

    localparam int            CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_MAX);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          last_q, last_d;

    logic cur_req;
    logic oth_req;
    logic cur_we;
    logic accept;
    logic pipe_valid;
    logic pipe_id;

    assign m0_gnt = (state_q == ARB_GNT0);
    assign m1_gnt = (state_q == ARB_GNT1);

    // Granted master's command; a flush cycle moves nothing onto the bus
    always_comb begin
        cur_req = 1'b0;
        oth_req = 1'b0;
        cur_we  = 1'b0;
        s_adr   = '0;
        s_wdata = '0;
        if (m0_gnt) begin
            cur_req = m0_req;
            oth_req = m1_req;
            cur_we  = m0_we;
            s_adr   = m0_adr;
            s_wdata = m0_wdata;
        end else if (m1_gnt) begin
            cur_req = m1_req;
            oth_req = m0_req;
            cur_we  = m1_we;
            s_adr   = m1_adr;
            s_wdata = m1_wdata;
        end
        accept = cur_req & ~rst_pipe;
        s_ren  = accept & ~cur_we;
        s_wen  = accept &  cur_we;
    end

    // Arbitration: tie goes to the master that did not win last; a tenure
    // ends on request drop, or after HOLD_MAX accepts if the other master waits
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cnt_inc = cnt_q + CW'(1);
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (m0_req && (!m1_req || last_q == M_HOST)) begin
                    state_d = ARB_GNT0;
                    last_d  = M_DMA;
                end else if (m1_req) begin
                    state_d = ARB_GNT1;
                    last_d  = M_HOST;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (!cur_req) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == HOLD_CNT) begin
                    cnt_d = '0;
                    if (oth_req) begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Flush aborts the tenure but keeps round-robin history
        if (rst_pipe) begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
            last_d  = last_q;
        end
    end

    // Arbiter state registers; after reset M0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            last_q  <= M_HOST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    io_rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_return_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (rst_pipe),
        .in_valid  (s_ren),
        .in_id     (m1_gnt),
        .out_valid (pipe_valid),
        .out_id    (pipe_id)
    );

    assign m0_rvalid = pipe_valid & (pipe_id == M_DMA);
    assign m1_rvalid = pipe_valid & (pipe_id == M_HOST);
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

endmodule : io_bus_arbiter
`default_nettype wire
